// File: rtl/bin_region_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bin_region_if : scan control, label BRAM read port and bin record stream
// Revision: 1.0
// ----------------------------------------------------------------------------
interface bin_region_if;
   logic        start;
   logic        busy;
   logic        done;
   logic [18:0] addr;
   logic [2:0]  bin_rd;
   logic        res_valid;
   logic        res_ready;
   logic [2:0]  res_bin;
   logic [18:0] res_count;
   logic [9:0]  res_xmin;
   logic [9:0]  res_xmax;
   logic [8:0]  res_ymin;
   logic [8:0]  res_ymax;

   modport master (
      input  start, bin_rd, res_ready,
      output busy, done, addr, res_valid, res_bin, res_count,
             res_xmin, res_xmax, res_ymin, res_ymax
   );

   modport slave (
      output start, bin_rd, res_ready,
      input  busy, done, addr, res_valid, res_bin, res_count,
             res_xmin, res_xmax, res_ymin, res_ymax
   );
endinterface
`default_nettype wire

// File: rtl/bin_region_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bin_region_reader : raster-scans the bin-label BRAM, reports count and bbox
//                     for bins 1..7 over a valid/ready stream
// Revision: 1.0
// ----------------------------------------------------------------------------
module bin_region_reader #(
   parameter int H_PIXELS     = 640,
   parameter int V_PIXELS     = 480,
   parameter int READ_LATENCY = 2
) (
   input  wire logic    clk,
   input  wire logic    reset,
   bin_region_if.master bus
);
   localparam logic [18:0] c_last_addr  = 19'(H_PIXELS * V_PIXELS - 1);
   localparam logic [9:0]  c_last_x     = 10'(H_PIXELS - 1);
   localparam logic [3:0]  c_drain_last = 4'(READ_LATENCY - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SCAN   = 3'd1,
      S_DRAIN  = 3'd2,
      S_REPORT = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t      r_state;
   logic [18:0] r_addr;
   logic [9:0]  r_x;
   logic [8:0]  r_y;
   logic [3:0]  r_drain;
   logic [2:0]  r_bin;
   logic        r_busy;
   logic        r_done;
   logic        r_res_valid;

   logic        r_pv [READ_LATENCY];
   logic [9:0]  r_px [READ_LATENCY];
   logic [8:0]  r_py [READ_LATENCY];

   logic [18:0] r_count [1:7];
   logic [9:0]  r_xmin  [1:7];
   logic [9:0]  r_xmax  [1:7];
   logic [8:0]  r_ymin  [1:7];
   logic [8:0]  r_ymax  [1:7];

   logic        w_acc;
   logic [9:0]  w_dx;
   logic [8:0]  w_dy;
   logic        w_start_ok;

   logic [2:0]  w_res_bin;
   logic [18:0] w_res_count;
   logic [9:0]  w_res_xmin;
   logic [9:0]  w_res_xmax;
   logic [8:0]  w_res_ymin;
   logic [8:0]  w_res_ymax;

   assign w_acc      = r_pv[READ_LATENCY-1] && (bus.bin_rd != 3'd0);
   assign w_dx       = r_px[READ_LATENCY-1];
   assign w_dy       = r_py[READ_LATENCY-1];
   assign w_start_ok = (r_state == S_IDLE) && bus.start;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_x         <= '0;
         r_y         <= '0;
         r_drain     <= '0;
         r_bin       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_res_valid <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_state <= S_SCAN;
                  r_busy  <= 1'b1;
                  r_addr  <= '0;
                  r_x     <= '0;
                  r_y     <= '0;
               end
            end
            S_SCAN: begin
               // addr is left on the last pixel once the frame has been issued
               if (r_addr == c_last_addr) begin
                  r_state <= S_DRAIN;
                  r_drain <= '0;
               end else begin
                  r_addr <= r_addr + 19'd1;
                  if (r_x == c_last_x) begin
                     r_x <= '0;
                     r_y <= r_y + 9'd1;
                  end else begin
                     r_x <= r_x + 10'd1;
                  end
               end
            end
            S_DRAIN: begin
               if (r_drain == c_drain_last) begin
                  r_state     <= S_REPORT;
                  r_bin       <= 3'd1;
                  r_res_valid <= 1'b1;
               end else begin
                  r_drain <= r_drain + 4'd1;
               end
            end
            S_REPORT: begin
               if (bus.res_ready) begin
                  if (r_bin == 3'd7) begin
                     r_res_valid <= 1'b0;
                     r_done      <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     r_bin <= r_bin + 3'd1;
                  end
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Issued coordinates travel alongside the BRAM read so they line up with bin_rd
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            r_pv[i] <= 1'b0;
            r_px[i] <= '0;
            r_py[i] <= '0;
         end
      end else begin
         r_pv[0] <= (r_state == S_SCAN);
         r_px[0] <= r_x;
         r_py[0] <= r_y;
         for (int i = 1; i < READ_LATENCY; i++) begin
            r_pv[i] <= r_pv[i-1];
            r_px[i] <= r_px[i-1];
            r_py[i] <= r_py[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int b = 1; b < 8; b++) begin
            r_count[b] <= '0;
            r_xmin[b]  <= '0;
            r_xmax[b]  <= '0;
            r_ymin[b]  <= '0;
            r_ymax[b]  <= '0;
         end
      end else if (w_start_ok) begin
         for (int b = 1; b < 8; b++) begin
            r_count[b] <= '0;
            r_xmin[b]  <= '1;
            r_xmax[b]  <= '0;
            r_ymin[b]  <= '1;
            r_ymax[b]  <= '0;
         end
      end else if (w_acc) begin
         r_count[bus.bin_rd] <= r_count[bus.bin_rd] + 19'd1;
         if (w_dx < r_xmin[bus.bin_rd]) r_xmin[bus.bin_rd] <= w_dx;
         if (w_dx > r_xmax[bus.bin_rd]) r_xmax[bus.bin_rd] <= w_dx;
         if (w_dy < r_ymin[bus.bin_rd]) r_ymin[bus.bin_rd] <= w_dy;
         if (w_dy > r_ymax[bus.bin_rd]) r_ymax[bus.bin_rd] <= w_dy;
      end
   end

   // Empty bins still hold the all-ones min seed, so the bbox is forced to 0
   always_comb begin
      w_res_bin   = '0;
      w_res_count = '0;
      w_res_xmin  = '0;
      w_res_xmax  = '0;
      w_res_ymin  = '0;
      w_res_ymax  = '0;
      if (r_res_valid) begin
         w_res_bin   = r_bin;
         w_res_count = r_count[r_bin];
         if (r_count[r_bin] != 19'd0) begin
            w_res_xmin = r_xmin[r_bin];
            w_res_xmax = r_xmax[r_bin];
            w_res_ymin = r_ymin[r_bin];
            w_res_ymax = r_ymax[r_bin];
         end
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.addr      = r_addr;
   assign bus.res_valid = r_res_valid;
   assign bus.res_bin   = w_res_bin;
   assign bus.res_count = w_res_count;
   assign bus.res_xmin  = w_res_xmin;
   assign bus.res_xmax  = w_res_xmax;
   assign bus.res_ymin  = w_res_ymin;
   assign bus.res_ymax  = w_res_ymax;

endmodule
`default_nettype wire

// File: tb/tb_bin_region_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bin_region_reader : directed bench on a reduced 40x12 frame
// Revision: 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bin_region_reader;
   localparam int H  = 40;
   localparam int V  = 12;
   localparam int N  = H * V;
   localparam int RL = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   bin_region_if bus();

   bin_region_reader #(
      .H_PIXELS(H), .V_PIXELS(V), .READ_LATENCY(RL)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Label BRAM model: two register stages from addr to bin_rd
   logic [2:0] mem [N];
   logic [2:0] rd1;
   always @(posedge clk) begin
      rd1        <= mem[bus.addr];
      bus.bin_rd <= rd1;
   end

   int total = 0;
   int bad   = 0;

   logic [59:0] rec     [7];
   logic [59:0] exp_rec [7];
   int n_rec, n_done, first_valid, stall_err;
   logic busy_after, busy_at_done;
   bit timed_out;

   function automatic logic [59:0] pack(input int b, input int c, input int x0,
                                        input int x1, input int y0, input int y1);
      return {3'(b), 19'(c), 10'(x0), 10'(x1), 9'(y0), 9'(y1)};
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < N; i++) mem[i] = 3'd0;
   endtask

   task automatic clear_exp();
      for (int i = 0; i < 7; i++) exp_rec[i] = pack(i + 1, 0, 0, 0, 0, 0);
   endtask

   // mode 0: ready always 1; mode 1: ready 1-0-0-1; mode 2: ready 1, start pulsed in SCAN and REPORT
   task automatic run_scan(input int mode);
      bit seen_done;
      int post;
      bit prev_stall;
      logic [59:0] cur, prev;
      n_rec = 0; n_done = 0; first_valid = -1; stall_err = 0;
      busy_after = 1'bx; busy_at_done = 1'bx; timed_out = 1'b0;
      seen_done = 1'b0; post = 0; prev_stall = 1'b0; prev = '0;
      for (int i = 0; i < 7; i++) rec[i] = '0;
      @(negedge clk);
      bus.start = 1'b1;
      for (int cyc = 1; cyc < N + 200; cyc++) begin
         @(negedge clk);
         bus.start     = 1'b0;
         bus.res_ready = (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         cur = {bus.res_bin, bus.res_count, bus.res_xmin, bus.res_xmax, bus.res_ymin, bus.res_ymax};
         if (prev_stall && (!bus.res_valid || cur !== prev)) stall_err++;
         if (bus.res_valid && first_valid < 0) first_valid = cyc;
         if (bus.res_valid && bus.res_ready) begin
            if (n_rec < 7) rec[n_rec] = cur;
            n_rec++;
         end
         prev_stall = bus.res_valid && !bus.res_ready;
         prev = cur;
         if (bus.done) begin
            n_done++;
            if (!seen_done) busy_at_done = bus.busy;
         end
         if (mode == 2 && !seen_done && (cyc == 10 || (bus.res_valid && n_rec == 2)))
            bus.start = 1'b1;
         if (seen_done) begin
            if (post == 0) busy_after = bus.busy;
            post++;
            if (post == 4) break;
         end
         if (bus.done) seen_done = 1'b1;
      end
      bus.start = 1'b0;
      timed_out = !seen_done;
   endtask

   task automatic test_reset();
      reset = 1'b1; bus.start = 1'b0; bus.res_ready = 1'b0;
      clear_mem();
      repeat (3) @(negedge clk);
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b exp 0", bus.done); end
      total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b exp 0", bus.res_valid); end
      total++; if (bus.addr !== 19'd0) begin bad++; $display("FAIL reset_addr: got %0d exp 0", bus.addr); end
      total++;
      if ({bus.res_bin, bus.res_count, bus.res_xmin} !== 32'd0) begin
         bad++; $display("FAIL reset_res: got %h exp 0", {bus.res_bin, bus.res_count, bus.res_xmin});
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_all_zero();
      clear_mem(); clear_exp();
      run_scan(0);
      total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL zero_timeout: got %b exp 0", timed_out); end
      total++; if (n_rec != 7) begin bad++; $display("FAIL zero_nrec: got %0d exp 7", n_rec); end
      total++; if (n_done != 1) begin bad++; $display("FAIL zero_ndone: got %0d exp 1", n_done); end
      total++; if (first_valid != N + RL + 1) begin bad++; $display("FAIL zero_latency: got %0d exp %0d", first_valid, N + RL + 1); end
      total++; if (busy_at_done !== 1'b1) begin bad++; $display("FAIL zero_busy_at_done: got %b exp 1", busy_at_done); end
      total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL zero_busy_after: got %b exp 0", busy_after); end
      for (int i = 0; i < 7; i++) begin
         total++;
         if (rec[i] !== exp_rec[i]) begin bad++; $display("FAIL zero_rec%0d: got %h exp %h", i + 1, rec[i], exp_rec[i]); end
      end
   endtask

   task automatic test_single_pixel();
      clear_mem(); clear_exp();
      mem[2 * H + 5] = 3'd3;
      exp_rec[2] = pack(3, 1, 5, 5, 2, 2);
      run_scan(0);
      total++; if (n_rec != 7 || timed_out) begin bad++; $display("FAIL single_nrec: got %0d timeout %b exp 7", n_rec, timed_out); end
      for (int i = 0; i < 7; i++) begin
         total++;
         if (rec[i] !== exp_rec[i]) begin bad++; $display("FAIL single_rec%0d: got %h exp %h", i + 1, rec[i], exp_rec[i]); end
      end
   endtask

   task automatic load_corners();
      clear_mem(); clear_exp();
      mem[0] = 3'd1; mem[N - 1] = 3'd1;
      mem[H - 1] = 3'd7; mem[(V - 1) * H] = 3'd7;
      exp_rec[0] = pack(1, 2, 0, H - 1, 0, V - 1);
      exp_rec[6] = pack(7, 2, 0, H - 1, 0, V - 1);
   endtask

   task automatic test_corners();
      load_corners();
      run_scan(0);
      total++; if (n_rec != 7 || timed_out) begin bad++; $display("FAIL corner_nrec: got %0d timeout %b exp 7", n_rec, timed_out); end
      for (int i = 0; i < 7; i++) begin
         total++;
         if (rec[i] !== exp_rec[i]) begin bad++; $display("FAIL corner_rec%0d: got %h exp %h", i + 1, rec[i], exp_rec[i]); end
      end
   endtask

   task automatic test_backpressure();
      clear_mem(); clear_exp();
      mem[1 * H + 3] = 3'd2; mem[4 * H + 10] = 3'd2; mem[9 * H + 7] = 3'd2;
      for (int x = 0; x < H; x++) mem[6 * H + x] = 3'd5;
      mem[5 * H + 20] = 3'd6;
      exp_rec[1] = pack(2, 3, 3, 10, 1, 9);
      exp_rec[4] = pack(5, H, 0, H - 1, 6, 6);
      exp_rec[5] = pack(6, 1, 20, 20, 5, 5);
      run_scan(1);
      total++; if (n_rec != 7 || timed_out) begin bad++; $display("FAIL bp_nrec: got %0d timeout %b exp 7", n_rec, timed_out); end
      total++; if (stall_err != 0) begin bad++; $display("FAIL bp_stall_stable: got %0d changes exp 0", stall_err); end
      total++; if (n_done != 1) begin bad++; $display("FAIL bp_ndone: got %0d exp 1", n_done); end
      for (int i = 0; i < 7; i++) begin
         total++;
         if (rec[i] !== exp_rec[i]) begin bad++; $display("FAIL bp_rec%0d: got %h exp %h", i + 1, rec[i], exp_rec[i]); end
      end
   endtask

   task automatic test_reset_midscan();
      bit hit;
      int dones;
      load_corners();
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < N; c++) begin
         if (bus.addr == 19'd200) begin hit = 1'b1; break; end
         @(negedge clk);
      end
      total++; if (!hit) begin bad++; $display("FAIL mid_reach_addr: got addr %0d exp 200", bus.addr); end
      reset = 1'b1;
      #1;
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b exp 0", bus.busy); end
      total++; if (bus.addr !== 19'd0) begin bad++; $display("FAIL mid_addr: got %0d exp 0", bus.addr); end
      @(negedge clk);
      reset = 1'b0;
      dones = 0;
      repeat (N + 10) begin
         @(negedge clk);
         if (bus.done || bus.res_valid || bus.busy) dones++;
      end
      total++; if (dones != 0) begin bad++; $display("FAIL mid_no_activity: got %0d active cycles exp 0", dones); end
      run_scan(0);
      total++; if (n_rec != 7 || n_done != 1) begin bad++; $display("FAIL mid_rescan: got nrec %0d ndone %0d exp 7/1", n_rec, n_done); end
      for (int i = 0; i < 7; i++) begin
         total++;
         if (rec[i] !== exp_rec[i]) begin bad++; $display("FAIL mid_rec%0d: got %h exp %h", i + 1, rec[i], exp_rec[i]); end
      end
   endtask

   task automatic test_start_ignored();
      clear_mem(); clear_exp();
      mem[2 * H + 5] = 3'd3;
      mem[7 * H + 30] = 3'd4;
      exp_rec[2] = pack(3, 1, 5, 5, 2, 2);
      exp_rec[3] = pack(4, 1, 30, 30, 7, 7);
      run_scan(2);
      total++; if (n_done != 1) begin bad++; $display("FAIL ign_ndone: got %0d exp 1", n_done); end
      total++; if (n_rec != 7 || timed_out) begin bad++; $display("FAIL ign_nrec: got %0d timeout %b exp 7", n_rec, timed_out); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ign_restart: got busy %b exp 0", bus.busy); end
      for (int i = 0; i < 7; i++) begin
         total++;
         if (rec[i] !== exp_rec[i]) begin bad++; $display("FAIL ign_rec%0d: got %h exp %h", i + 1, rec[i], exp_rec[i]); end
      end
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.res_ready = 1'b0;
      reset         = 1'b1;
      test_reset();
      test_all_zero();
      test_single_pixel();
      test_corners();
      test_backpressure();
      test_reset_midscan();
      test_start_ignored();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion exp finish before 2ms");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
